// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: redirect in, instruction-memory request/response, and the valid/ok output to the buffer.
// master = fetch unit side, slave = environment side (memory, buffer, redirect source).
// FETCH_ERR_EN adds imem_rsp_err / out_err.
interface fetch_unit_if #(
    parameter int XLEN      = 32,
    parameter int INST_SIZE = 32
);
    logic                 redirect_valid;
    logic [XLEN-1:0]      redirect_pc;
    logic                 imem_req_valid;
    logic [XLEN-1:0]      imem_req_addr;
    logic                 imem_req_ready;
    logic                 imem_rsp_valid;
    logic [INST_SIZE-1:0] imem_rsp_data;
    logic                 out_valid;
    logic [INST_SIZE-1:0] out_inst;
    logic [XLEN-1:0]      out_pc;
    logic                 out_ok;
    logic                 flush_o;
`ifdef FETCH_ERR_EN
    logic                 imem_rsp_err;
    logic                 out_err;

    modport master (
        input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err, out_ok,
        output imem_req_valid, imem_req_addr, out_valid, out_inst, out_pc, out_err, flush_o
    );
    modport slave (
        output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err, out_ok,
        input  imem_req_valid, imem_req_addr, out_valid, out_inst, out_pc, out_err, flush_o
    );
`else
    modport master (
        input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ok,
        output imem_req_valid, imem_req_addr, out_valid, out_inst, out_pc, flush_o
    );
    modport slave (
        output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ok,
        input  imem_req_valid, imem_req_addr, out_valid, out_inst, out_pc, flush_o
    );
`endif
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, one imem request in flight, redirect flushes and restarts (FETCH_ERR_EN adds error halt).
// Latency: request cycle -> out_valid two cycles later with a 1-cycle memory; 1 instruction per 2 cycles sustained.
// Backpressure: no new request while out_valid && !out_ok; outputs held stable until accepted.
module fetch_unit #(
    parameter int              XLEN      = 32,
    parameter int              INST_SIZE = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master fi
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
`ifdef FETCH_ERR_EN
        , S_HALT = 2'd3
`endif
    } state_t;

    state_t               state, state_nxt;
    logic [XLEN-1:0]      pc, inflight_pc;
    logic                 out_valid_q;
    logic [INST_SIZE-1:0] out_inst_q;
    logic [XLEN-1:0]      out_pc_q;
    logic                 req_valid_c;
    logic                 req_fire;
    logic                 capture;
    logic                 unused_pc_lsb;

    assign unused_pc_lsb = ^fi.redirect_pc[1:0];
    assign req_fire      = req_valid_c && fi.imem_req_ready;
    assign capture       = (state == S_WAIT) && fi.imem_rsp_valid && !fi.redirect_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_REQ;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_REQ:  if (req_fire) state_nxt = S_WAIT;
            S_WAIT: begin
                if (fi.redirect_valid)
                    state_nxt = fi.imem_rsp_valid ? S_REQ : S_DROP;
                else if (fi.imem_rsp_valid)
`ifdef FETCH_ERR_EN
                    state_nxt = fi.imem_rsp_err ? S_HALT : S_REQ;
`else
                    state_nxt = S_REQ;
`endif
            end
            // A redirect here does not change anything: the stale response is still owed.
            S_DROP: if (fi.imem_rsp_valid) state_nxt = S_REQ;
`ifdef FETCH_ERR_EN
            S_HALT: if (fi.redirect_valid) state_nxt = S_REQ;
`endif
            default: state_nxt = S_REQ;
        endcase
    end

    // Requests only when the output is empty or draining, so WAIT never finds it occupied.
    always_comb begin
        req_valid_c = 1'b0;
        if (rst_n && state == S_REQ)
            req_valid_c = (!out_valid_q || fi.out_ok) && !fi.redirect_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            inflight_pc <= '0;
        end else if (fi.redirect_valid) begin
            pc <= {fi.redirect_pc[XLEN-1:2], 2'b00};
        end else if (req_fire) begin
            inflight_pc <= pc;
            pc          <= pc + XLEN'(4);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_inst_q  <= '0;
            out_pc_q    <= '0;
        end else if (fi.redirect_valid) begin
            out_valid_q <= 1'b0;
        end else if (capture) begin
            out_valid_q <= 1'b1;
            out_inst_q  <= fi.imem_rsp_data;
            out_pc_q    <= inflight_pc;
        end else if (out_valid_q && fi.out_ok) begin
            out_valid_q <= 1'b0;
        end
    end

`ifdef FETCH_ERR_EN
    logic out_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       out_err_q <= 1'b0;
        else if (capture) out_err_q <= fi.imem_rsp_err;
    end

    assign fi.out_err = out_valid_q && out_err_q;
`endif

    assign fi.imem_req_valid = req_valid_c;
    assign fi.imem_req_addr  = pc;
    assign fi.out_valid      = out_valid_q;
    assign fi.out_inst       = out_inst_q;
    assign fi.out_pc         = out_pc_q;
    assign fi.flush_o        = fi.redirect_valid;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage directly upstream of the pipeline fifo buffer.
- Owns the PC and issues word-aligned instruction requests to the instruction memory port, one request in flight at a time.
- Presents each returned instruction word with its PC on a valid/ok output, which connects to the fifo's data_i/valide/ok.
- On a redirect (branch or exception), drives flush to the buffer, discards stale in-flight data and restarts at the new PC.

Parameters:
XLEN, 32, width of the PC and addresses
INST_SIZE, 32, width of an instruction word
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
redirect_valid  in  1  single-cycle redirect request
redirect_pc  in  XLEN  new fetch PC; bits[1:0] ignored, forced to 0
imem_req_valid  out  1  request valid
imem_req_addr  out  XLEN  request address, always word-aligned
imem_req_ready  in  1  memory accepts the request this cycle
imem_rsp_valid  in  1  response valid; exactly one response per accepted request; no backpressure
imem_rsp_data  in  INST_SIZE  instruction word
out_valid  out  1  out_inst/out_pc valid
out_inst  out  INST_SIZE  instruction to the buffer
out_pc  out  XLEN  PC of out_inst
out_ok  in  1  downstream accepts; transfer = out_valid && out_ok
flush_o  out  1  flush to the downstream buffer

Behaviour:
- Clock and reset: one clock, clk; rst_n is asynchronous, active-low.
- Reset values: pc=RESET_PC, state=REQ, out_valid=0, out_inst=0, out_pc=0, imem_req_valid=0 while rst_n=0.
- FSM states: REQ, WAIT, DROP (plus HALT when FETCH_ERR_EN is defined).
- REQ state:
  - imem_req_valid = (!out_valid || out_ok) && !redirect_valid.
  - imem_req_addr = pc.
  - On handshake: inflight_pc <= pc; pc <= pc + 4 (wraps modulo 2^XLEN); next state WAIT.
- WAIT state, on imem_rsp_valid:
  - out_inst <= imem_rsp_data; out_pc <= inflight_pc; out_valid <= 1; next state REQ.
  - The output register is always free at this point, because a request is only issued when the output is empty or draining.
- Output drain: out_valid && out_ok with no new capture -> out_valid <= 0. Outputs are held stable while out_valid && !out_ok.
- Redirect (any state, redirect_valid=1):
  - flush_o = redirect_valid (combinational, same cycle).
  - pc <= {redirect_pc[XLEN-1:2], 2'b00}; out_valid <= 0 next cycle.
  - From WAIT without imem_rsp_valid: next state DROP.
  - From WAIT with imem_rsp_valid in the same cycle: the response is discarded; next state REQ.
  - From REQ: no request is issued that cycle; next state REQ.
  - From DROP: stay in DROP, unless imem_rsp_valid arrives that cycle, in which case go to REQ.
  - Redirect has priority over output capture and drain.
- DROP state: the next imem_rsp_valid is discarded (no output update); next state REQ.
- Latency and throughput:
  - With a 1-cycle memory, the first request is at the first clock after rst_n rises and out_valid rises 2 cycles after request acceptance.
  - Sustained throughput is 1 instruction per 2 cycles.
- Reset mid-operation: returns to the reset state immediately; in-flight responses are the memory's responsibility (it is reset with the same rst_n).

Optional Feature:
Macro FETCH_ERR_EN.
- Defined:
  - Adds input imem_rsp_err (1) and output out_err (1).
  - An erroring response is captured like a normal one with out_err=1.
  - The FSM enters HALT and issues no requests until redirect_valid, which follows normal redirect rules to REQ.
  - out_err resets to 0 and is qualified by out_valid.
- Undefined: the ports and the HALT state do not exist.

Test Plan:
1. Reset release, imem_req_ready=1, 1-cycle memory, out_ok=1 -> request addresses 0x0, 0x4, 0x8; out_pc 0x0, 0x4, 0x8 in order, one every 2 cycles.
2. out_ok=0 for 5 cycles with out_valid=1 (out_pc=0x4) -> outputs held stable, imem_req_valid=0; once out_ok=1, the next request is 0x8.
3. Redirect to 0x100 while in WAIT (response arrives 3 cycles later) -> flush_o=1 that cycle, stale response dropped, next request 0x100, next out_pc 0x100.
4. Redirect to 0x203 coinciding with imem_rsp_valid -> response discarded, no DROP state, next request 0x200.
5. rst_n low mid-WAIT -> out_valid=0 immediately; after release, first request is RESET_PC.
6. FETCH_ERR_EN: error response at PC 0x8 -> out_err=1 with out_pc=0x8, no further requests until redirect to 0x40, then fetch resumes at 0x40.
